// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues req/ready fetches, absorbs wait states,
// buffers a word across a freeze and squashes fetches made stale by a branch.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_taken,
   input  logic [31:0] branchAddr,
   input  logic        freeze,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic        flush
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] wait_count,
   output logic [31:0] squash_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, tgt_reg, buf_inst_reg, buf_pc_reg;
   logic [31:0] pc_plus4;
   logic        done;

   assign pc_plus4 = pc_reg + 32'd4;
   assign done     = mem_req & mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            if (branch_taken)      state_next = done ? REQ : DROP;
            else if (done && freeze) state_next = HOLD;
         end
         HOLD: if (branch_taken || !freeze) state_next = REQ;
         DROP: if (done) state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   // An outstanding request cannot be aborted, so DROP keeps requesting the old address.
   always_comb begin
      mem_req  = (state_reg == REQ) || (state_reg == DROP);
      mem_addr = {pc_reg[31:2], 2'b00};
      flush    = branch_taken;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg       <= RESET_PC;
         tgt_reg      <= 32'd0;
         buf_inst_reg <= 32'd0;
         buf_pc_reg   <= 32'd0;
      end else begin
         case (state_reg)
            REQ: begin
               if (branch_taken) begin
                  if (done) pc_reg  <= branchAddr;
                  else      tgt_reg <= branchAddr;
               end else if (done) begin
                  pc_reg <= pc_plus4;
                  if (freeze) begin
                     buf_inst_reg <= mem_rdata;
                     buf_pc_reg   <= pc_plus4;
                  end
               end
            end
            HOLD: if (branch_taken) pc_reg <= branchAddr;
            DROP: begin
               if (done)              pc_reg  <= branch_taken ? branchAddr : tgt_reg;
               else if (branch_taken) tgt_reg <= branchAddr;
            end
            default: ;
         endcase
      end
   end

   // A branch always kills the presented instruction, even under freeze.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_valid  <= 1'b0;
         Instruction <= 32'd0;
         PC          <= 32'd0;
      end else if (branch_taken) begin
         inst_valid <= 1'b0;
      end else begin
         case (state_reg)
            REQ: begin
               if (done && !freeze) begin
                  inst_valid  <= 1'b1;
                  Instruction <= mem_rdata;
                  PC          <= pc_plus4;
               end else if (!done && !freeze) begin
                  inst_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!freeze) begin
                  inst_valid  <= 1'b1;
                  Instruction <= buf_inst_reg;
                  PC          <= buf_pc_reg;
               end
            end
            DROP: if (!freeze) inst_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic fetch_inc, wait_inc, squash_inc;

   assign fetch_inc  = (state_reg == REQ) && done && !branch_taken;
   assign wait_inc   = mem_req && !mem_ready;
   assign squash_inc = ((state_reg == REQ) && done && branch_taken) ||
                       ((state_reg == DROP) && done) ||
                       ((state_reg == HOLD) && branch_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count  <= 32'd0;
         wait_count   <= 32'd0;
         squash_count <= 32'd0;
      end else begin
         if (fetch_inc)  fetch_count  <= fetch_count + 32'd1;
         if (wait_inc)   wait_count   <= wait_count + 32'd1;
         if (squash_inc) squash_count <= squash_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a random run
// compared against a queue-based fetch model.
module tb_fetch_controller;

   logic        clk;
   logic        rst;
   logic        branch_taken;
   logic [31:0] branchAddr;
   logic        freeze;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic        flush;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, wait_count, squash_count;
`endif

   int errors = 0;
   int checks = 0;

   fetch_controller #(.RESET_PC(32'd0)) dut (
      .clk(clk), .rst(rst), .branch_taken(branch_taken), .branchAddr(branchAddr),
      .freeze(freeze), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .inst_valid(inst_valid), .Instruction(Instruction),
      .PC(PC), .flush(flush)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count), .wait_count(wait_count), .squash_count(squash_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   assign mem_rdata = mem_f(mem_addr);

   // Model: fetch address, a stale flag for an in-flight squashed fetch, and a
   // one-entry queue holding a word fetched while the pipeline was frozen.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } word_t;

   bit          m_started, m_stale;
   logic [31:0] m_pc, m_tgt;
   word_t       m_held[$];
   logic        m_valid;
   logic [31:0] m_inst, m_pcout;

   logic        c_req, c_flush, e_req;
   logic [31:0] c_addr, e_addr;

   task automatic model_reset();
      m_started = 0; m_stale = 0; m_pc = 32'd0; m_tgt = 32'd0;
      m_held.delete(); m_valid = 1'b0; m_inst = 32'd0; m_pcout = 32'd0;
   endtask

   task automatic model_step(input logic br, input logic [31:0] ba, input logic frz, input logic rdy);
      bit          req;
      bit          dn;
      logic [31:0] a;
      word_t       w;
      req = m_started && (m_held.size() == 0);
      dn  = req && rdy;
      a   = {m_pc[31:2], 2'b00};
      if (!m_started) begin
         m_started = 1;
         if (br) m_valid = 1'b0;
      end else if (m_held.size() != 0) begin
         if (br) begin
            m_held.delete(); m_pc = ba; m_valid = 1'b0;
         end else if (!frz) begin
            w = m_held.pop_front();
            m_valid = 1'b1; m_inst = w.inst; m_pcout = w.pc;
         end
      end else if (m_stale) begin
         if (dn) begin
            m_pc = br ? ba : m_tgt; m_stale = 0;
         end else if (br) m_tgt = ba;
         if (br || !frz) m_valid = 1'b0;
      end else begin
         if (br) begin
            m_valid = 1'b0;
            if (dn) m_pc = ba;
            else begin m_stale = 1; m_tgt = ba; end
         end else if (dn) begin
            if (frz) m_held.push_back('{mem_f(a), m_pc + 32'd4});
            else begin m_valid = 1'b1; m_inst = mem_f(a); m_pcout = m_pc + 32'd4; end
            m_pc = m_pc + 32'd4;
         end else if (!frz) m_valid = 1'b0;
      end
   endtask

   // Drive one cycle: capture combinational outputs mid-cycle, then step past the edge.
   task automatic cycle(input logic br, input logic [31:0] ba, input logic frz, input logic rdy);
      branch_taken = br; branchAddr = ba; freeze = frz; mem_ready = rdy;
      #2;
      c_req = mem_req; c_addr = mem_addr; c_flush = flush;
      e_req = m_started && (m_held.size() == 0);
      e_addr = {m_pc[31:2], 2'b00};
      model_step(br, ba, frz, rdy);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; branch_taken = 1'b0; branchAddr = 32'd0; freeze = 1'b0; mem_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; branch_taken = 1'b0; branchAddr = 32'd0; freeze = 1'b0; mem_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      checks++; if (Instruction !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h want 0", Instruction); end
      checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", PC); end
      rst = 1'b0;
      cycle(0, 0, 0, 1);
      checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", c_req); end
      $display("test_reset done");
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1);
         checks++; if (c_req !== 1'b1 || c_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got req=%b addr=%h want 1/%h", i, c_req, c_addr, 32'(4 * i)); end
         checks++; if (inst_valid !== 1'b1 || PC !== 32'(4 * i + 4) || Instruction !== mem_f(32'(4 * i))) begin
            errors++; $display("FAIL seq_out%0d: got v=%b pc=%h inst=%h want 1/%h/%h", i, inst_valid, PC, Instruction, 32'(4 * i + 4), mem_f(32'(4 * i)));
         end
         $display("seq fetch addr=%h pc=%h inst=%h", c_addr, PC, Instruction);
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 0, 0);
         checks++; if (c_addr !== 32'd8) begin errors++; $display("FAIL wait_addr%0d: got %h want 8", i, c_addr); end
         checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble%0d: got %b want 0", i, inst_valid); end
      end
      cycle(0, 0, 0, 1);
      checks++; if (c_addr !== 32'd8) begin errors++; $display("FAIL wait_addr_done: got %h want 8", c_addr); end
      checks++; if (inst_valid !== 1'b1 || PC !== 32'd12 || Instruction !== mem_f(32'd8)) begin
         errors++; $display("FAIL wait_out: got v=%b pc=%h inst=%h want 1/c/%h", inst_valid, PC, Instruction, mem_f(32'd8));
      end
      $display("wait fetch addr=8 pc=%h inst=%h", PC, Instruction);
   endtask

   task automatic test_freeze_hold();
      do_reset();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 1);
      checks++; if (inst_valid !== 1'b1 || PC !== 32'd4) begin errors++; $display("FAIL frz_held: got v=%b pc=%h want 1/4", inst_valid, PC); end
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 1, 1);
         checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL frz_hold_req%0d: got %b want 0", i, c_req); end
         checks++; if (PC !== 32'd4) begin errors++; $display("FAIL frz_hold_pc%0d: got %h want 4", i, PC); end
      end
      cycle(0, 0, 0, 1);
      checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL frz_release_req: got %b want 0", c_req); end
      checks++; if (inst_valid !== 1'b1 || PC !== 32'd8 || Instruction !== mem_f(32'd4)) begin
         errors++; $display("FAIL frz_out: got v=%b pc=%h inst=%h want 1/8/%h", inst_valid, PC, Instruction, mem_f(32'd4));
      end
      cycle(0, 0, 0, 1);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'd8) begin errors++; $display("FAIL frz_next: got req=%b addr=%h want 1/8", c_req, c_addr); end
      $display("freeze fetch pc=%h inst=%h", PC, Instruction);
   endtask

   task automatic test_branch_during_wait();
      do_reset();
      repeat (4) cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      cycle(1, 32'h100, 0, 0);
      checks++; if (c_flush !== 1'b1) begin errors++; $display("FAIL bw_flush: got %b want 1", c_flush); end
      checks++; if (c_addr !== 32'd12) begin errors++; $display("FAIL bw_addr: got %h want c", c_addr); end
      cycle(0, 0, 0, 0);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'd12) begin errors++; $display("FAIL bw_drop_addr: got req=%b addr=%h want 1/c", c_req, c_addr); end
      cycle(0, 0, 0, 1);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bw_discard: got v=%b pc=%h want v=0", inst_valid, PC); end
      cycle(0, 0, 0, 1);
      checks++; if (c_addr !== 32'h100) begin errors++; $display("FAIL bw_target: got %h want 100", c_addr); end
      checks++; if (inst_valid !== 1'b1 || PC !== 32'h104) begin errors++; $display("FAIL bw_out: got v=%b pc=%h want 1/104", inst_valid, PC); end
      $display("branch fetch pc=%h inst=%h", PC, Instruction);
   endtask

   task automatic test_branch_completion_freeze();
      do_reset();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(1, 32'h200, 1, 1);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bcf_valid: got %b want 0", inst_valid); end
      cycle(0, 0, 1, 0);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'h200) begin errors++; $display("FAIL bcf_addr: got req=%b addr=%h want 1/200", c_req, c_addr); end
      cycle(0, 0, 0, 1);
      checks++; if (inst_valid !== 1'b1 || PC !== 32'h204 || Instruction !== mem_f(32'h200)) begin
         errors++; $display("FAIL bcf_out: got v=%b pc=%h inst=%h want 1/204/%h", inst_valid, PC, Instruction, mem_f(32'h200));
      end
      $display("branch+freeze fetch pc=%h inst=%h", PC, Instruction);
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      mem_ready = 1'b1; rst = 1'b1;
      model_reset();
      #2;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmw_req: got %b want 0", mem_req); end
      checks++; if (inst_valid !== 1'b0 || Instruction !== 32'd0 || PC !== 32'd0) begin
         errors++; $display("FAIL rmw_out: got v=%b inst=%h pc=%h want 0/0/0", inst_valid, Instruction, PC);
      end
`ifdef FETCH_PERF_EN
      checks++; if (fetch_count !== 32'd0 || wait_count !== 32'd0 || squash_count !== 32'd0) begin
         errors++; $display("FAIL rmw_counters: got %0d/%0d/%0d want 0/0/0", fetch_count, wait_count, squash_count);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(0, 0, 0, 1);
      checks++; if (c_req !== 1'b0) begin errors++; $display("FAIL rmw_idle: got %b want 0", c_req); end
      cycle(0, 0, 0, 1);
      checks++; if (c_req !== 1'b1 || c_addr !== 32'd0) begin errors++; $display("FAIL rmw_first: got req=%b addr=%h want 1/0", c_req, c_addr); end
      $display("reset mid-wait fetch pc=%h inst=%h", PC, Instruction);
   endtask

   task automatic test_random();
      logic        br, frz, rdy;
      logic [31:0] ba;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         br  = ($urandom_range(0, 99) < 8);
         frz = ($urandom_range(0, 99) < 25);
         rdy = ($urandom_range(0, 99) < 70);
         ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 3))) : $urandom;
         cycle(br, ba, frz, rdy);
         checks++; if (c_req !== e_req) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", n, c_req, e_req); end
         if (e_req) begin
            checks++; if (c_addr !== e_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", n, c_addr, e_addr); end
         end
         checks++; if (c_flush !== br) begin errors++; $display("FAIL rnd_flush@%0d: got %b want %b", n, c_flush, br); end
         checks++; if (inst_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, inst_valid, m_valid); end
         checks++; if (Instruction !== m_inst) begin errors++; $display("FAIL rnd_inst@%0d: got %h want %h", n, Instruction, m_inst); end
         checks++; if (PC !== m_pcout) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, PC, m_pcout); end
         $display("rnd %0d br=%b frz=%b rdy=%b addr=%h v=%b pc=%h", n, br, frz, rdy, c_addr, inst_valid, PC);
      end
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; branchAddr = 32'd0; freeze = 1'b0; mem_ready = 1'b0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_freeze_hold();
      test_branch_during_wait();
      test_branch_completion_freeze();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
